// File: rtl/fpu_pred_arbiter_if.sv
// Bundle between the requesters, the round-robin predicate arbiter and the shared predicate unit.
// The slave modport is the arbiter's view; the master modport is the requester/unit side.
interface fpu_pred_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_op;
    logic [2*NREQ-1:0]    req_fn;
    logic                 unit_start;
    logic [31:0]          unit_op;
    logic [1:0]           unit_fn;
    logic                 unit_result;
    logic                 unit_ready;
    logic [NREQ-1:0]      resp_valid;
    logic                 resp_result;
    logic                 resp_err;
    logic                 busy;

    modport slave (
        input  req_valid, req_op, req_fn, unit_result, unit_ready,
        output unit_start, unit_op, unit_fn, resp_valid, resp_result, resp_err, busy
    );

    modport master (
        output req_valid, req_op, req_fn, unit_result, unit_ready,
        input  unit_start, unit_op, unit_fn, resp_valid, resp_result, resp_err, busy
    );
endinterface

// File: rtl/fpu_pred_arbiter.sv
// Round-robin arbiter sharing one single-precision predicate unit among NREQ requesters,
// with a WAIT-cycle timeout that answers result=0, err=1 when the unit never completes.
module fpu_pred_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    fpu_pred_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   pick;
    logic            found;
    logic [7:0]      cnt;
    logic [31:0]     op_q;
    logic [1:0]      fn_q;
    logic            start_q;
    logic            result_q;
    logic            err_q;
    logic [NREQ-1:0] resp_q;

    // First pending requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[(int'(ptr) + j) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + j) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            winner   <= '0;
            cnt      <= '0;
            op_q     <= '0;
            fn_q     <= '0;
            start_q  <= 1'b0;
            result_q <= 1'b0;
            err_q    <= 1'b0;
            resp_q   <= '0;
        end else begin
            start_q <= 1'b0;
            resp_q  <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner  <= pick;
                        op_q    <= bus.req_op[32*int'(pick) +: 32];
                        fn_q    <= bus.req_fn[2*int'(pick) +: 2];
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A ready in the final allowed cycle beats the timeout.
                    if (bus.unit_ready) begin
                        result_q <= bus.unit_result;
                        err_q    <= 1'b0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(TIMEOUT - 1)) begin
                            result_q <= 1'b0;
                            err_q    <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_q <= NREQ'(1) << winner;
                    ptr    <= (int'(winner) == NREQ - 1) ? '0 : winner + IW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unit_start  = start_q;
    assign bus.unit_op     = op_q;
    assign bus.unit_fn     = fn_q;
    assign bus.resp_valid  = resp_q;
    assign bus.resp_result = result_q;
    assign bus.resp_err    = err_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_fpu_pred_arbiter.sv
// Directed plus randomized checks of fpu_pred_arbiter against a transaction-level model
// holding the pending set, the round-robin pointer and the expected response timing.
module tb_fpu_pred_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int ptrModel = 0;

    bit          pend  [NREQ];
    logic [31:0] opArr [NREQ];
    logic [1:0]  fnArr [NREQ];

    fpu_pred_arbiter_if #(.NREQ(NREQ)) bus ();

    fpu_pred_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [31:0] op, input logic [1:0] fn);
        pend[i]               = 1'b1;
        opArr[i]              = op;
        fnArr[i]              = fn;
        bus.req_valid[i]      = 1'b1;
        bus.req_op[32*i +: 32] = op;
        bus.req_fn[2*i +: 2]   = fn;
    endtask

    task automatic dropReq(input int i);
        pend[i]          = 1'b0;
        bus.req_valid[i] = 1'b0;
    endtask

    function automatic int modelWinner();
        for (int j = 0; j < NREQ; j++) begin
            if (pend[(ptrModel + j) % NREQ]) return (ptrModel + j) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkQuiet(input string tag);
        checkOutput({tag, " unit_start"}, 32'(bus.unit_start), 32'd0);
        checkOutput({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Requests are already on the bus at the current negedge; the unit answers in WAIT cycle k.
    task automatic runTxn(input int k, input logic r, input bit drop, input bit keep);
        int   w;
        int   len;
        logic expRes;
        logic expErr;
        w = modelWinner();
        if (w < 0) return;
        len    = ((k <= TIMEOUT) ? k : TIMEOUT) + 2;
        expRes = (k <= TIMEOUT) ? r : 1'b0;
        expErr = (k > TIMEOUT);
        @(negedge clk);
        bus.unit_ready = 1'b0;
        checkOutput("unit_start at issue", 32'(bus.unit_start), 32'd1);
        checkOutput("unit_op at issue", bus.unit_op, opArr[w]);
        checkOutput("unit_fn at issue", 32'(bus.unit_fn), 32'(fnArr[w]));
        checkOutput("busy at issue", 32'(bus.busy), 32'd1);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c < len) begin
                checkOutput("unit_start after issue", 32'(bus.unit_start), 32'd0);
                checkOutput("resp_valid early", 32'(bus.resp_valid), 32'd0);
                checkOutput("busy in flight", 32'(bus.busy), 32'd1);
                if (c == len - 1) checkOutput("unit_op held", bus.unit_op, opArr[w]);
                bus.unit_ready  = (c == k);
                bus.unit_result = (c == k) ? r : ~r;
                if (drop && c == 1) dropReq(w);
            end else begin
                bus.unit_ready = 1'b0;
                checkOutput("resp_valid", 32'(bus.resp_valid), 32'(1 << w));
                checkOutput("resp_result", 32'(bus.resp_result), 32'(expRes));
                checkOutput("resp_err", 32'(bus.resp_err), 32'(expErr));
                checkOutput("busy after resp", 32'(bus.busy), 32'd0);
                ptrModel = (w + 1) % NREQ;
                if (!keep) dropReq(w);
            end
        end
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_op      = '0;
        bus.req_fn      = '0;
        bus.unit_ready  = 1'b0;
        bus.unit_result = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opArr[i] = '0;
            fnArr[i] = '0;
        end

        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset unit_op", bus.unit_op, 32'd0);
        checkOutput("reset unit_fn", 32'(bus.unit_fn), 32'd0);
        checkOutput("reset resp_result", 32'(bus.resp_result), 32'd0);
        checkOutput("reset resp_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b1;

        repeat (2) begin
            @(negedge clk);
            checkQuiet("idle");
        end

        $display("[TB] single request");
        applyStimulus(0, 32'h3F80_0000, 2'b00);
        runTxn(1, 1'b1, 1'b0, 1'b0);

        $display("[TB] four requesters held continuously");
        for (int i = 0; i < NREQ; i++) applyStimulus(i, $urandom, 2'(i));
        repeat (5) runTxn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        repeat (4) runTxn(2, 1'b1, 1'b0, 1'b0);

        $display("[TB] timeout then normal request");
        applyStimulus(2, $urandom, 2'b01);
        runTxn(TIMEOUT + 5, 1'b1, 1'b0, 1'b0);
        applyStimulus(3, $urandom, 2'b10);
        runTxn(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] ready during RESP, then ready on timeout cycle");
        applyStimulus(0, $urandom, 2'b11);
        runTxn(TIMEOUT + 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(3, $urandom, 2'b00);
        runTxn(TIMEOUT, 1'b1, 1'b0, 1'b0);

        $display("[TB] granted requester drops during WAIT");
        applyStimulus(0, $urandom, 2'b00);
        applyStimulus(1, $urandom, 2'b01);
        runTxn(3, 1'b1, 1'b1, 1'b0);
        runTxn(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during WAIT");
        applyStimulus(2, $urandom, 2'b10);
        runTxn(2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, $urandom, 2'b00);
        applyStimulus(3, $urandom, 2'b01);
        @(negedge clk);
        checkOutput("pre-reset grant op", bus.unit_op, opArr[3]);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkQuiet("mid-txn reset");
        checkOutput("mid-txn reset unit_op", bus.unit_op, 32'd0);
        checkOutput("mid-txn reset unit_fn", 32'(bus.unit_fn), 32'd0);
        bus.unit_ready  = 1'b1;
        bus.unit_result = 1'b1;
        ptrModel = 0;
        runTxn(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    applyStimulus(i, $urandom, 2'($urandom_range(0, 3)));
            end
            if (modelWinner() < 0)
                applyStimulus(int'($urandom_range(0, NREQ - 1)), $urandom, 2'b11);
            runTxn(int'($urandom_range(1, TIMEOUT + 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
